// File: rtl/fma_share_ctrl.sv
// fma_share_ctrl: shares one combinational fused multiply-add datapath
// between NumReq requesters. A round-robin arbiter feeds an operand stage
// (S1) that drives the datapath; a result stage (S2) captures the datapath
// output and returns it to the owning requester over a shared result bus.
// Both stages use valid/ready flow control, giving one op per cycle and a
// fixed two-cycle latency when the consumer never stalls.
module fma_share_ctrl #(
  parameter int NumReq   = 2,
  parameter int MulWidth = 54,
  parameter int OutWidth = 164
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  // request side
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*MulWidth-1:0]   req_multiplier_i,
  input  logic [NumReq*MulWidth-1:0]   req_multiplicand_i,
  input  logic [NumReq*OutWidth-1:0]   req_addend1_i,
  input  logic [NumReq*OutWidth-1:0]   req_addend2_i,
  // response side
  output logic [NumReq-1:0]            resp_valid_o,
  input  logic [NumReq-1:0]            resp_ready_i,
  output logic [OutWidth-1:0]          resp_result_o,
  // shared datapath
  output logic [MulWidth-1:0]          dp_multiplier_o,
  output logic [MulWidth-1:0]          dp_multiplicand_o,
  output logic [OutWidth-1:0]          dp_addend1_o,
  output logic [OutWidth-1:0]          dp_addend2_o,
  input  logic [OutWidth-1:0]          dp_result_i,
  // status
  output logic                         busy_o
);

  // A single requester still needs a 1-bit id so the id registers exist.
  localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [IdW-1:0] LastId = IdW'(NumReq - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic                r_v1;
  logic [IdW-1:0]      r_id1;
  logic [MulWidth-1:0] r_mul;
  logic [MulWidth-1:0] r_mcand;
  logic [OutWidth-1:0] r_add1;
  logic [OutWidth-1:0] r_add2;

  logic                r_v2;
  logic [IdW-1:0]      r_id2;
  logic [OutWidth-1:0] r_result;

  logic [IdW-1:0]      r_rr;

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic                w_found;
  logic [IdW-1:0]      w_winner;
  logic [IdW-1:0]      w_rr_next;
  logic                w_handshake;
  logic                w_resp_taken;
  logic                w_s2_free;
  logic                w_s1_free;
  logic [MulWidth-1:0] w_sel_mul;
  logic [MulWidth-1:0] w_sel_mcand;
  logic [OutWidth-1:0] w_sel_add1;
  logic [OutWidth-1:0] w_sel_add2;

  // Round-robin search: first pass covers ids at or above the pointer,
  // second pass wraps around to the ids below it.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!w_found && req_valid_i[i] && (IdW'(i) >= r_rr)) begin
        w_found  = 1'b1;
        w_winner = IdW'(i);
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!w_found && req_valid_i[i]) begin
        w_found  = 1'b1;
        w_winner = IdW'(i);
      end
    end
  end

  // Pointer moves to the requester after the winner, wrapping at NumReq.
  always_comb begin
    w_rr_next = '0;
    if (w_winner != LastId) begin
      w_rr_next = w_winner + 1'b1;
    end
  end

  // S2 is free when empty or when its owner takes the result this cycle;
  // S1 can then advance into S2, so it is free under the same condition.
  assign w_resp_taken = |(resp_valid_o & resp_ready_i);
  assign w_s2_free    = !r_v2 || w_resp_taken;
  assign w_s1_free    = !r_v1 || w_s2_free;
  assign w_handshake  = w_found && w_s1_free;

  // Operand mux selecting the winner's four operands.
  always_comb begin
    w_sel_mul   = '0;
    w_sel_mcand = '0;
    w_sel_add1  = '0;
    w_sel_add2  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (w_winner == IdW'(i)) begin
        w_sel_mul   = req_multiplier_i[i*MulWidth +: MulWidth];
        w_sel_mcand = req_multiplicand_i[i*MulWidth +: MulWidth];
        w_sel_add1  = req_addend1_i[i*OutWidth +: OutWidth];
        w_sel_add2  = req_addend2_i[i*OutWidth +: OutWidth];
      end
    end
  end

  // Per-requester ready and valid decode.
  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_port
      assign req_ready_o[gi]  = w_handshake && (w_winner == IdW'(gi));
      assign resp_valid_o[gi] = r_v2 && (r_id2 == IdW'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------

  // Arbitration pointer advances only when a grant is actually taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr <= '0;
    end else if (w_handshake) begin
      r_rr <= w_rr_next;
    end
  end

  // S1 valid/owner: load on handshake, empty when it drains with no refill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v1  <= 1'b0;
      r_id1 <= '0;
    end else if (w_handshake) begin
      r_v1  <= 1'b1;
      r_id1 <= w_winner;
    end else if (w_s1_free) begin
      r_v1  <= 1'b0;
    end
  end

  // S1 operands: only written on handshake, so the datapath inputs keep
  // their last values while the stage is empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mul   <= '0;
      r_mcand <= '0;
      r_add1  <= '0;
      r_add2  <= '0;
    end else if (w_handshake) begin
      r_mul   <= w_sel_mul;
      r_mcand <= w_sel_mcand;
      r_add1  <= w_sel_add1;
      r_add2  <= w_sel_add2;
    end
  end

  // S2: capture the datapath result when S1 holds an op and S2 can accept;
  // otherwise hold while stalled, or empty once the result is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v2     <= 1'b0;
      r_id2    <= '0;
      r_result <= '0;
    end else if (r_v1 && w_s2_free) begin
      r_v2     <= 1'b1;
      r_id2    <= r_id1;
      r_result <= dp_result_i;
    end else if (w_s2_free) begin
      r_v2     <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign dp_multiplier_o   = r_mul;
  assign dp_multiplicand_o = r_mcand;
  assign dp_addend1_o      = r_add1;
  assign dp_addend2_o      = r_add2;
  assign resp_result_o     = r_result;
  assign busy_o            = r_v1 || r_v2;

endmodule
